// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle integer multiply/divide unit for the execute stage.
//   Operations (op): 0=MULU, 1=MUL (signed), 2=DIVU, 3=DIV (signed).
//   A multiply runs the 2*WIDTH product through a MUL_LAT-deep register
//   pipeline. A divide performs restoring division on magnitudes, one
//   quotient bit per cycle, followed by a sign-fix cycle. Division by
//   zero returns lo=all ones and hi=a without iterating.
//
//   Optional feature macro: MULDIV_EARLY_OUT_EN
//     When defined, a divide with |a| < |b| (b nonzero) returns lo=0 and
//     hi=a one cycle after accept instead of iterating. Results are the
//     same in both builds; only latency differs.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               abort any operation, return to IDLE (hi/lo held)
//   in_valid, in_ready  request handshake (in_ready only in IDLE)
//   op, a, b            operation and operands
//   out_valid, out_ready result handshake (result held under backpressure)
//   hi, lo              product upper/lower half, or remainder/quotient
//   busy                unit not idle (execute-stage stall)
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  // The counter sequences both the divide iterations and the multiply
  // pipeline, so it is sized for whichever needs more.
  localparam int DIV_CW = $clog2(WIDTH + 1);
  localparam int MUL_CW = $clog2(MUL_LAT + 1);
  localparam int CNT_W  = (DIV_CW > MUL_CW) ? DIV_CW : MUL_CW;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] prod_p [MUL_LAT];
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvs;
  logic               neg_q;
  logic               neg_r;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic                      accept;
  logic                      a_neg;
  logic                      b_neg;
  logic [WIDTH-1:0]          a_mag;
  logic [WIDTH-1:0]          b_mag;
  logic                      b_zero;
  logic                      div_skip;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]            trial;
  logic                      trial_ok;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Sign-extend in signed mode, zero-extend otherwise; the low 2*WIDTH
  // bits of the product are then exact for both interpretations.
  assign a_ext     = {{WIDTH{op[0] & a[WIDTH-1]}}, a};
  assign b_ext     = {{WIDTH{op[0] & b[WIDTH-1]}}, b};
  assign prod_full = a_ext * b_ext;

  assign a_neg  = op[0] & a[WIDTH-1];
  assign b_neg  = op[0] & b[WIDTH-1];
  assign a_mag  = cond_neg(a, a_neg);
  assign b_mag  = cond_neg(b, b_neg);
  assign b_zero = (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign div_skip = b_zero | (a_mag < b_mag);
`else
  assign div_skip = b_zero;
`endif

  // Trial subtraction: a clear top bit means the shifted remainder
  // covers the divisor and this quotient bit is 1.
  assign trial    = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign trial_ok = !trial[WIDTH];

  // ---- datapath: operand capture, product pipeline, divide iteration ----
  always_ff @(posedge clk) begin
    if (accept) begin
      prod_p[0] <= prod_full;
    end
    for (int i = 1; i < MUL_LAT; i++) begin
      prod_p[i] <= prod_p[i-1];
    end

    if (accept) begin
      dvs <= b_mag;
      if (b_zero) begin
        quo   <= '1;
        rem   <= a;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (div_skip) begin
        quo   <= '0;
        rem   <= a;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        quo   <= a_mag;
        rem   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (state == DIV && cnt != DIV_LAST) begin
      quo <= {quo[WIDTH-2:0], trial_ok};
      if (trial_ok) begin
        rem <= trial[WIDTH-1:0];
      end else begin
        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
      end
    end
  end

  // ---- control: state, sequencing counter, result registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op[1]) begin
              state <= DIV;
              // Skipped divides go straight to the final (sign-fix) step.
              cnt   <= div_skip ? DIV_LAST : '0;
            end else begin
              state <= MUL;
              cnt   <= '0;
            end
          end
        end
        MUL: begin
          if (cnt == MUL_LAST) begin
            hi        <= prod_p[MUL_LAT-1][2*WIDTH-1:WIDTH];
            lo        <= prod_p[MUL_LAT-1][WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (cnt == DIV_LAST) begin
            hi        <= cond_neg(rem, neg_r);
            lo        <= cond_neg(quo, neg_q);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int ML = 3;
  localparam int DL = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = W + 1;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        if (!seen) begin
          check({sb[0].name, "_latency"}, cyc, sb[0].due);
          seen = 1'b1;
        end
        check({sb[0].name, "_hi"}, hi, sb[0].hi);
        check({sb[0].name, "_lo"}, lo, sb[0].lo);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input int lat, input string name);
    exp_t e;
    int   k = 0;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    if (!in_ready) check({name, "_ready_wait"}, {63'd0, in_ready}, 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.due = cyc + lat; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((sb.size() != 0 || !in_ready) && k < 200) begin
      tick();
      k++;
    end
    check({name, "_drained"}, {63'd0, (sb.size() == 0 && in_ready)}, 64'd1);
    if (sb.size() != 0) begin
      sb.delete();
      seen = 1'b0;
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] ehi, input logic [W-1:0] elo,
                     input int lat, input string name);
    issue(o, x, y, 1'b1, ehi, elo, lat, name);
    wait_done(name);
  endtask

  task automatic check_idle_reset_vals(input string name);
    check({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({name, "_hi"}, hi, 64'd0);
    check({name, "_lo"}, lo, 64'd0);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 2'd0;
    a = '0; b = '0; out_ready = 1'b1;
    repeat (2) tick();
    check_idle_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Multiply
    run(2'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, ML, "mul_m3x5");
    run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, ML, "mulu_max");
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, ML, "mul_m1xm1");
    run(2'd0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, ML, "mulu_shift");

    // Divide
    run(2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DL, "div_m7d2");
    run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DL, "div_min_m1");
    run(2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DL, "div_7dm2");
    run(2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        DL, "divu_100d7");
    run(2'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, DL, "divu_max_d1");
    run(2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  "divu_by0");
    run(2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  "div_by0");
    run(2'd2, 32'd3,         32'd10,        32'd3,         32'd0,         EO_LAT, "divu_3d10");
    run(2'd3, 32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 32'd0,         EO_LAT, "div_m3d10");

    // Flush mid-divide with a simultaneous request
    issue(2'd3, 32'd100, 32'd3, 1'b0, '0, '0, 0, "flush_div");
    repeat (9) tick();
    flush = 1'b1; in_valid = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy",      {63'd0, busy},      64'd0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready",  {63'd0, in_ready},  64'd1);
    check("flush_hi_held",   hi, 64'hFFFF_FFFD);
    check("flush_lo_held",   lo, 64'd0);
    repeat (40) tick();
    check("flush_still_idle", {63'd0, busy}, 64'd0);
    run(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, ML, "mulu_after_flush");

    // Backpressure: result held for 20 cycles, no accept while DONE
    out_ready = 1'b0;
    issue(2'd0, 32'h0000_FFFF, 32'h0001_0001, 1'b1, 32'd0, 32'hFFFF_FFFF, ML, "mulu_bp");
    repeat (ML) tick();
    in_valid = 1'b1; op = 2'd2; a = 32'd9; b = 32'd4;
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready",  {63'd0, in_ready},  64'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done("mulu_bp");

    // Reset in the middle of a divide
    issue(2'd3, 32'd1000, 32'd7, 1'b0, '0, '0, 0, "reset_div");
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_idle_reset_vals("midreset");
    reset = 1'b0;
    tick();
    run(2'd3, 32'd1000, 32'd7, 32'd6, 32'd142, DL, "div_after_reset");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
